// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin front end for one shared pipelined ALU.
// Grants one requester per cycle, registers its operands into the ALU input
// stage, carries the requester id alongside the ALU pipeline and returns the
// registered result tagged with that id. Latency from handshake to result is
// fixed at ALU_LAT+2 cycles whatever the contention.
module alu_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int IN_W    = 18,
  parameter int C_W     = 48,
  parameter int OUT_W   = 48,
  parameter int ALU_LAT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*IN_W-1:0]         req_a,
  input  logic [N_REQ*IN_W-1:0]         req_b,
  input  logic [N_REQ*IN_W-1:0]         req_d,
  input  logic [N_REQ*C_W-1:0]          req_c,
  input  logic [N_REQ-1:0]              req_cin,
  input  logic [N_REQ*2-1:0]            req_sel,
  output logic [IN_W-1:0]               alu_a,
  output logic [IN_W-1:0]               alu_b,
  output logic [IN_W-1:0]               alu_d,
  output logic [C_W-1:0]                alu_c,
  output logic                          alu_cin,
  output logic [1:0]                    alu_sel,
  input  logic [OUT_W-1:0]              alu_p,
  output logic                          res_valid,
  output logic [$clog2(N_REQ)-1:0]      res_id,
  output logic [OUT_W-1:0]              res_p,
  output logic [$clog2(ALU_LAT+3)-1:0]  inflight
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ALU_LAT + 3);
  // One tag stage sits beside the operand registers, then ALU_LAT stages
  // track the ALU itself, so the last stage lines up with a valid alu_p.
  localparam int TAG_DEPTH = ALU_LAT + 1;
  localparam int TAG_LAST  = TAG_DEPTH - 1;

  logic [ID_W-1:0]      ptr;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic [N_REQ-1:0]     grant_vec;

  logic [TAG_DEPTH-1:0] tag_valid;
  logic [ID_W-1:0]      tag_id [TAG_DEPTH];

  logic                 retire;

  // Round-robin search: first valid requester at or after ptr, modulo N_REQ.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    logic             found;
    logic [ID_W-1:0]  idx;
    found       = 1'b0;
    idx         = '0;
    grant_id    = '0;
    grant_vec   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // NOTE: blocking assignments in combinational logic; the loop relies
      // on seeing the updated value of found within the same evaluation.
      idx = ptr + ID_W'(k);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    grant_valid = en && !rst && found;
    if (grant_valid) begin
      grant_vec[grant_id] = 1'b1;
    end
  end

  assign req_ready = grant_vec;

  // Priority pointer moves just past the last granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block order.
      ptr <= grant_id + ID_W'(1);
    end
  end

  // ALU input stage: load the winner's operands, otherwise hold to avoid toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_d   <= '0;
      alu_c   <= '0;
      alu_cin <= 1'b0;
      alu_sel <= '0;
    end else if (grant_valid) begin
      alu_a   <= req_a[grant_id*IN_W +: IN_W];
      alu_b   <= req_b[grant_id*IN_W +: IN_W];
      alu_d   <= req_d[grant_id*IN_W +: IN_W];
      alu_c   <= req_c[grant_id*C_W +: C_W];
      alu_cin <= req_cin[grant_id];
      alu_sel <= req_sel[grant_id*2 +: 2];
    end
  end

  // Tag pipeline: {valid, id} shifts every cycle in step with the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      // NOTE: the id array is small and reset explicitly so a reset leaves
      // the whole tag pipeline in a known state, not only the valid bits.
      for (int s = 0; s < TAG_DEPTH; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_valid[0] <= grant_valid;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < TAG_DEPTH; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  assign retire = tag_valid[TAG_LAST];

  // Result register: capture alu_p with its id when the last tag is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_p     <= '0;
    end else begin
      res_valid <= retire;
      if (retire) begin
        res_id <= tag_id[TAG_LAST];
        res_p  <= alu_p;
      end
    end
  end

  // Outstanding count: up on a grant, down when a result is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({grant_valid, retire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with a behavioural ALU model in the loop
// and a scoreboard that pairs every grant with its returned result.
module tb_alu_rr_sched;

  localparam int N_REQ   = 4;
  localparam int IN_W    = 18;
  localparam int C_W     = 48;
  localparam int OUT_W   = 48;
  localparam int ALU_LAT = 3;
  localparam int LAT     = ALU_LAT + 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*IN_W-1:0]   req_a, req_b, req_d;
  logic [N_REQ*C_W-1:0]    req_c;
  logic [N_REQ-1:0]        req_cin;
  logic [N_REQ*2-1:0]      req_sel;
  logic [IN_W-1:0]         alu_a, alu_b, alu_d;
  logic [C_W-1:0]          alu_c;
  logic                    alu_cin;
  logic [1:0]              alu_sel;
  logic [OUT_W-1:0]        alu_p;
  logic                    res_valid;
  logic [1:0]              res_id;
  logic [OUT_W-1:0]        res_p;
  logic [2:0]              inflight;

  alu_rr_sched #(
    .N_REQ(N_REQ), .IN_W(IN_W), .C_W(C_W), .OUT_W(OUT_W), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c),
    .req_cin(req_cin), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_c(alu_c),
    .alu_cin(alu_cin), .alu_sel(alu_sel), .alu_p(alu_p),
    .res_valid(res_valid), .res_id(res_id), .res_p(res_p),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural ALU: 0 = a*b+c+cin, 1 = (d+a)*b+c+cin, 2 = c-a*b-cin, 3 = c^{a,b}.
  function automatic logic [47:0] alu_model(input logic [17:0] a, input logic [17:0] b,
                                            input logic [17:0] d, input logic [47:0] c,
                                            input logic cin, input logic [1:0] sel);
    logic [47:0] a48, b48, d48, ci;
    a48 = 48'(a);
    b48 = 48'(b);
    d48 = 48'(d);
    ci  = 48'(cin);
    case (sel)
      2'd0:    return a48 * b48 + c + ci;
      2'd1:    return (d48 + a48) * b48 + c + ci;
      2'd2:    return c - a48 * b48 - ci;
      default: return c ^ {12'h000, a, b};
    endcase
  endfunction

  // ALU pipeline model: ALU_LAT edges from alu_* to alu_p.
  logic [47:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_model(alu_a, alu_b, alu_d, alu_c, alu_cin, alu_sel);
    for (int s = 1; s < ALU_LAT; s++) alu_pipe[s] <= alu_pipe[s-1];
  end
  assign alu_p = alu_pipe[ALU_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every handshake expects a matching result LAT cycles later.
  typedef struct {
    int          id;
    logic [47:0] p;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          check("sb_spurious_result", 64'd1, 64'd0);
        end else begin
          e_mon = sb.pop_front();
          check("sb_id", 64'(res_id), 64'(e_mon.id));
          check("sb_p", 64'(res_p), 64'(e_mon.p));
          check("sb_latency", 64'(cyc - e_mon.cyc), 64'(LAT));
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{i, alu_model(req_a[i*IN_W +: IN_W], req_b[i*IN_W +: IN_W],
                                      req_d[i*IN_W +: IN_W], req_c[i*C_W +: C_W],
                                      req_cin[i], req_sel[i*2 +: 2]), cyc});
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic [17:0] a, input logic [17:0] b,
                         input logic [17:0] d, input logic [47:0] c,
                         input logic cin, input logic [1:0] sel);
    req_a[i*IN_W +: IN_W] = a;
    req_b[i*IN_W +: IN_W] = b;
    req_d[i*IN_W +: IN_W] = d;
    req_c[i*C_W +: C_W]   = c;
    req_cin[i]            = cin;
    req_sel[i*2 +: 2]     = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [3:0]  exp3 [3];
  logic [3:0]  exp5 [3];
  logic [47:0] exp6 [4];
  logic [47:0] exp1;
  int          g_cnt, c_cnt;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < N_REQ; i++) begin
      set_ops(i, 18'(i * 4099 + 7), 18'(i * 517 + 3), 18'(i * 33 + 1),
              48'(i) * 48'h10000001 + 48'h55, i[0], 2'(i));
    end

    // Reset: no grants while rst is high, all state zero afterwards.
    @(negedge clk);
    check("rst_ready_0", 64'(req_ready), 64'd0);
    tick();
    @(negedge clk);
    check("rst_ready_1", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    req_valid = 4'h0;
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_c", 64'(alu_c), 64'd0);
    check("rst_res_p", 64'(res_p), 64'd0);
    tick();

    // Single request from requester 0.
    set_ops(0, 18'h12345, 18'h23456, 18'h34567, 48'h456789ABCDEF, 1'b1, 2'd2);
    exp1 = alu_model(18'h12345, 18'h23456, 18'h34567, 48'h456789ABCDEF, 1'b1, 2'd2);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = 4'b0000;
    for (int m = 1; m <= 6; m++) begin
      @(negedge clk);
      if (m == 1) begin
        check("t1_alu_a", 64'(alu_a), 64'h12345);
        check("t1_alu_b", 64'(alu_b), 64'h23456);
        check("t1_alu_d", 64'(alu_d), 64'h34567);
        check("t1_alu_c", 64'(alu_c), 64'h456789ABCDEF);
        check("t1_alu_cin", 64'(alu_cin), 64'd1);
        check("t1_alu_sel", 64'(alu_sel), 64'd2);
      end
      check($sformatf("t1_inflight_%0d", m), 64'(inflight), (m <= 4) ? 64'd1 : 64'd0);
      check($sformatf("t1_res_valid_%0d", m), 64'(res_valid), (m == 5) ? 64'd1 : 64'd0);
      if (m == 5) begin
        check("t1_res_id", 64'(res_id), 64'd0);
        check("t1_res_p", 64'(res_p), 64'(exp1));
      end
      tick();
    end

    // Full contention from ptr=0: grants rotate, inflight saturates at 4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int m = 0; m < 14; m++) begin
      req_valid = (m < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (m < 8) check($sformatf("t2_ready_%0d", m), 64'(req_ready), 64'(4'b0001 << (m % 4)));
      g_cnt = (m < 8) ? m : 8;
      c_cnt = (m <= 4) ? 0 : (((m - 4) > 8) ? 8 : (m - 4));
      check($sformatf("t2_inflight_%0d", m), 64'(inflight), 64'(g_cnt - c_cnt));
      check($sformatf("t2_res_valid_%0d", m), 64'(res_valid),
            (m >= 5 && m < 13) ? 64'd1 : 64'd0);
      if (m >= 5 && m < 13) check($sformatf("t2_res_id_%0d", m), 64'(res_id), 64'((m - 5) % 4));
      tick();
    end

    // Pointer wrap / fairness: last grant was 3, so ptr is 0.
    exp3[0] = 4'b0001;
    exp3[1] = 4'b1000;
    exp3[2] = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b1001;
      @(negedge clk);
      check($sformatf("t3_ready_%0d", k), 64'(req_ready), 64'(exp3[k]));
      tick();
    end
    req_valid = 4'b0000;
    idle(7);

    // Enable gating: ptr is 1; one grant, then en low for 3 cycles.
    req_valid = 4'b0110;
    @(negedge clk);
    check("t4_ready_pre", 64'(req_ready), 64'b0010);
    tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t4_ready_off_%0d", k), 64'(req_ready), 64'd0);
      tick();
    end
    en = 1'b1;
    @(negedge clk);
    check("t4_ready_on", 64'(req_ready), 64'b0100);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("t4_res_valid", 64'(res_valid), 64'd1);
    check("t4_res_id", 64'(res_id), 64'd1);
    tick();
    idle(6);

    // Reset mid-flight: ptr is 3; three grants, reset two cycles later.
    exp5[0] = 4'b1000;
    exp5[1] = 4'b0001;
    exp5[2] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'hF;
      @(negedge clk);
      check($sformatf("t5_ready_%0d", k), 64'(req_ready), 64'(exp5[k]));
      tick();
    end
    req_valid = 4'h0;
    tick();
    rst = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    check("t5_ready_in_rst", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    req_valid = 4'h0;
    @(negedge clk);
    check("t5_inflight", 64'(inflight), 64'd0);
    check("t5_alu_a", 64'(alu_a), 64'd0);
    check("t5_alu_b", 64'(alu_b), 64'd0);
    check("t5_alu_d", 64'(alu_d), 64'd0);
    check("t5_alu_c", 64'(alu_c), 64'd0);
    check("t5_alu_cin", 64'(alu_cin), 64'd0);
    check("t5_alu_sel", 64'(alu_sel), 64'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t5_no_result_%0d", k), 64'(res_valid), 64'd0);
      tick();
    end
    req_valid = 4'b1110;
    @(negedge clk);
    check("t5_ptr_after_rst", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'h0;
    idle(7);

    // Select sweep on requester 2 alone, including an all-ones a operand.
    for (int s = 0; s < 4; s++) begin
      set_ops(2, 18'h3FFFF, 18'h00003, 18'h00010, 48'hFFFF00001234, 1'b1, 2'(s));
      exp6[s] = alu_model(18'h3FFFF, 18'h00003, 18'h00010, 48'hFFFF00001234, 1'b1, 2'(s));
      req_valid = 4'b0100;
      @(negedge clk);
      check($sformatf("t6_ready_%0d", s), 64'(req_ready), 64'b0100);
      tick();
    end
    req_valid = 4'h0;
    for (int m = 4; m < 10; m++) begin
      @(negedge clk);
      check($sformatf("t6_res_valid_%0d", m), 64'(res_valid),
            (m >= 5 && m <= 8) ? 64'd1 : 64'd0);
      if (m >= 5 && m <= 8) begin
        check($sformatf("t6_res_id_%0d", m), 64'(res_id), 64'd2);
        check($sformatf("t6_res_p_%0d", m), 64'(res_p), 64'(exp6[m-5]));
      end
      tick();
    end

    idle(3);
    check("sb_drain", 64'(sb.size()), 64'd0);
    check("final_inflight", 64'(inflight), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
